// File: rtl/ddr_line_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ddr_line_if : request/response bus between the tester and the DDR2 line   |
// |               RAM wrapper.                                      rev 1.0   |
// +---------------------------------------------------------------------------+
interface ddr_line_if #(
  parameter int ADDR_W = 24,
  parameter int LINE_W = 128
);
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              wend;
  logic              rend;

  modport master (output we, re, addr, wdata, input rdata, wend, rend);
  modport slave  (input we, re, addr, wdata, output rdata, wend, rend);
endinterface
`default_nettype wire

// File: rtl/ddr_line_tester.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ddr_line_tester : writes NLINES pattern lines, reads them back and counts |
// |                   mismatching words.                            rev 1.0   |
// +---------------------------------------------------------------------------+
module ddr_line_tester #(
  parameter int WORD_W  = 16,
  parameter int WORDS   = 8,
  parameter int ADDR_W  = 24,
  parameter int STRIDE  = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 4096,
  localparam int LINE_W = WORD_W * WORDS,
  localparam int SEL_W  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_start,
  input  wire logic [1:0]        i_mode,
  input  wire logic [ADDR_W-1:0] i_base_addr,
  input  wire logic [CNT_W-1:0]  i_num_lines,
  input  wire logic [WORD_W-1:0] i_seed,
  input  wire logic [SEL_W-1:0]  i_sel,
  ddr_line_if.master             mem,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_pass,
  output logic                   o_timeout,
  output logic [CNT_W-1:0]       o_err_count,
  output logic [ADDR_W-1:0]      o_fail_addr,
  output logic [WORD_W-1:0]      o_dbg_word
);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int MIS_W = $clog2(WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_CHECK   = 3'd5,
    S_FIN     = 3'd6
  } state_t;

  state_t            r_state;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_last;
  logic [WORD_W-1:0] r_seed;
  logic [CNT_W-1:0]  r_idx;
  logic [TW-1:0]     r_tcnt;
  logic              r_we;
  logic              r_re;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_line;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_err;
  logic [ADDR_W-1:0] r_fail_addr;

  logic              w_inv;
  logic              w_last;
  logic              w_tmo;
  logic [ADDR_W-1:0] w_line_addr;
  logic [LINE_W-1:0] w_pat;
  logic [MIS_W-1:0]  w_nmis;
  logic [CNT_W:0]    w_sum;
  logic [CNT_W-1:0]  w_err_next;

  assign w_inv       = (r_mode == 2'd3);
  assign w_last      = (r_idx == r_last);
  assign w_tmo       = (r_tcnt == TW'(TIMEOUT - 1));
  assign w_line_addr = r_base + ADDR_W'(r_idx) * ADDR_W'(STRIDE);

  // Expected pattern of the current line, shared by the write and check phases
  for (genvar k = 0; k < WORDS; k++) begin : g_pat
    logic [WORD_W-1:0] w_word;
    assign w_word = r_seed + WORD_W'(r_idx) * WORD_W'(WORDS) + WORD_W'(k);
    assign w_pat[k*WORD_W +: WORD_W] = w_inv ? ~w_word : w_word;
  end

  always_comb begin
    w_nmis = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (r_line[k*WORD_W +: WORD_W] != w_pat[k*WORD_W +: WORD_W])
        w_nmis = w_nmis + MIS_W'(1);
    end
  end

  assign w_sum      = {1'b0, r_err} + (CNT_W+1)'(w_nmis);
  assign w_err_next = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= '0;
      r_base      <= '0;
      r_last      <= '0;
      r_seed      <= '0;
      r_idx       <= '0;
      r_tcnt      <= '0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_line      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err       <= '0;
      r_fail_addr <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode      <= i_mode;
            r_base      <= i_base_addr;
            r_last      <= (i_num_lines == '0) ? '0 : i_num_lines - CNT_W'(1);
            r_seed      <= i_seed;
            r_idx       <= '0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err       <= '0;
            r_fail_addr <= '0;
            r_busy      <= 1'b1;
            r_state     <= (i_mode == 2'd2) ? S_RD_REQ : S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (!mem.wend) begin
            r_we    <= 1'b1;
            r_addr  <= w_line_addr;
            r_wdata <= w_pat;
            r_tcnt  <= '0;
            r_state <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (mem.wend) begin
            r_we <= 1'b0;
            if (!w_last) begin
              r_idx   <= r_idx + CNT_W'(1);
              r_state <= S_WR_REQ;
            end else if (r_mode == 2'd1) begin
              r_done  <= 1'b1;
              r_pass  <= (r_err == '0);
              r_state <= S_FIN;
            end else begin
              r_idx   <= '0;
              r_state <= S_RD_REQ;
            end
          end else if (w_tmo) begin
            r_we      <= 1'b0;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_FIN;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_RD_REQ: begin
          if (!mem.rend) begin
            r_re    <= 1'b1;
            r_addr  <= w_line_addr;
            r_tcnt  <= '0;
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (mem.rend) begin
            r_re    <= 1'b0;
            r_line  <= mem.rdata;
            r_state <= S_CHECK;
          end else if (w_tmo) begin
            r_re      <= 1'b0;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_FIN;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_CHECK: begin
          r_err <= w_err_next;
          // err_count never returns to zero, so zero means no earlier mismatch
          if (w_nmis != '0 && r_err == '0)
            r_fail_addr <= r_addr;
          if (w_last) begin
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0) && !r_timeout;
            r_state <= S_FIN;
          end else begin
            r_idx   <= r_idx + CNT_W'(1);
            r_state <= S_RD_REQ;
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.we      = r_we;
  assign mem.re      = r_re;
  assign mem.addr    = r_addr;
  assign mem.wdata   = r_wdata;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_timeout   = r_timeout;
  assign o_err_count = r_err;
  assign o_fail_addr = r_fail_addr;
  assign o_dbg_word  = r_line[i_sel*WORD_W +: WORD_W];
endmodule
`default_nettype wire
